// File: rtl/cd_mult_seq_if.sv
// Handshake and data bundle for the sequential carry-disregard multiplier.
// The master side supplies operands and consumes results; the slave side is the multiplier.
interface cd_mult_seq_if #(
    parameter int WA = 8,
    parameter int WB = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WA-1:0]    a;
    logic [WB-1:0]    b;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WA+WB-1:0] result;
    logic             out_approx;

    modport master (
        output in_valid, a, b, approx_en, out_ready,
        input  in_ready, out_valid, result, out_approx
    );

    modport slave (
        input  in_valid, a, b, approx_en, out_ready,
        output in_ready, out_valid, result, out_approx
    );
endinterface

// File: rtl/cd_mult_seq.sv
// Sequential WA x WB multiplier, one partial-product row per cycle. In approximate mode the
// low K columns are combined by XOR, so no carry is generated into or out of that field.
module cd_mult_seq #(
    parameter int WA = 8,
    parameter int WB = 4,
    parameter int K  = 5
) (
    input logic           clk,
    input logic           rst,
    cd_mult_seq_if.slave  bus
);
    localparam int N  = WA + WB;
    localparam int CW = (WB > 1) ? $clog2(WB) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(WB - 1);
    localparam logic [N-1:0]  LOW_MASK = ~({N{1'b1}} << K);

    if (K < 0 || K > N || WB < 1 || WA < 2) begin : g_param_err
        $error("cd_mult_seq: illegal parameters (need WA>=2, WB>=1, 0<=K<=WA+WB)");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    logic [WA-1:0]   r_a;
    logic [WB-1:0]   r_b;
    logic            r_mode;
    logic [N-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [N-1:0]    r_result;
    logic            r_out_approx;

    logic            w_accept;
    logic [N-1:0]    w_pp;
    logic [N-1:0]    w_row;
    logic [N-1:0]    w_mask;
    logic [N-1:0]    w_hi;
    logic [N-1:0]    w_acc_nxt;

    assign bus.in_ready   = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.out_approx = r_out_approx;

    assign w_accept = bus.in_valid & bus.in_ready;

    assign w_pp  = {{WB{1'b0}}, r_a & {WA{r_b[r_cnt]}}};
    assign w_row = w_pp << r_cnt;

    // Masked operands have zero low fields, so the add cannot carry out of the XOR field
    // and nothing from the XOR field can carry into it.
    assign w_mask    = r_mode ? LOW_MASK : '0;
    assign w_hi      = (r_acc & ~w_mask) + (w_row & ~w_mask);
    assign w_acc_nxt = w_hi | ((r_acc ^ w_row) & w_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_mode       <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_out_approx <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_mode  <= bus.approx_en;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ROW) begin
                        r_result     <= w_acc_nxt;
                        r_out_approx <= r_mode;
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        // A pending operand is taken in the same cycle as the result handshake.
                        if (bus.in_valid) begin
                            r_a     <= bus.a;
                            r_b     <= bus.b;
                            r_mode  <= bus.approx_en;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cd_mult_seq.sv
// Bench for cd_mult_seq: known vectors, exhaustive and random sweeps against an arithmetic
// reference, plus hand sequences for backpressure, back-to-back issue and mid-run reset.
`timescale 1ns/1ps
module tb_cd_mult_seq;
    localparam int WA = 8;
    localparam int WB = 4;
    localparam int K  = 5;
    localparam int N  = WA + WB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cd_mult_seq_if #(.WA(WA), .WB(WB)) bus ();

    cd_mult_seq #(.WA(WA), .WB(WB), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        logic          m;
        logic [N-1:0]  exp_r;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Low field: XOR of the rows' low bits. High field: plain sum of the rows' upper parts.
    function automatic logic [N-1:0] ref_mul(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                             input logic m);
        int     keff = m ? K : 0;
        longint lo = 0;
        longint hi = 0;
        longint row;
        for (int i = 0; i < WB; i++) begin
            row = b[i] ? (longint'(a) << i) : 0;
            lo  = lo ^ (row & ((longint'(1) << keff) - 1));
            hi  = hi + (row >> keff);
        end
        return N'((hi << keff) | lo);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, hold the result under backpressure for 'hold' cycles,
    // then hand it off and confirm the block returns to IDLE.
    task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic m,
                         input logic [N-1:0] exp_r, input int hold, input string tag);
        int lat;
        chk({tag, ".in_ready_idle"}, bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.approx_en = m;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid  = 1'b0;
        bus.a         = WA'($urandom);
        bus.b         = WB'($urandom);
        bus.approx_en = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, ".latency"}, lat, WB);
        chk({tag, ".result"}, bus.result, exp_r);
        chk({tag, ".out_approx"}, bus.out_approx, m);
        for (int i = 0; i < hold; i++) begin
            bus.a         = WA'($urandom);
            bus.b         = WB'($urandom);
            bus.approx_en = 1'($urandom);
            step();
            chk({tag, ".hold_valid"}, bus.out_valid, 1);
            chk({tag, ".hold_result"}, bus.result, exp_r);
            chk({tag, ".hold_approx"}, bus.out_approx, m);
            chk({tag, ".hold_in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, ".post_valid"}, bus.out_valid, 0);
        chk({tag, ".post_in_ready"}, bus.in_ready, 1);
    endtask

    vec_t vecs[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] res1;
        int           cnt;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", bus.out_valid, 0);
        chk("reset.result", bus.result, 0);
        chk("reset.out_approx", bus.out_approx, 0);
        rst = 1'b0;
        step();
        chk("reset.in_ready", bus.in_ready, 1);

        vecs = '{
            '{8'hFF, 4'hF, 1'b1, 12'hE85},
            '{8'hFF, 4'hF, 1'b0, 12'hEF1},
            '{8'h03, 4'h3, 1'b1, 12'h005},
            '{8'h03, 4'h3, 1'b0, 12'h009},
            '{8'h05, 4'h3, 1'b1, 12'h00F},
            '{8'h00, 4'hF, 1'b1, 12'h000},
            '{8'hFF, 4'h0, 1'b0, 12'h000},
            '{8'h12, 4'h5, 1'b0, 12'h05A},
            '{8'h01, 4'h1, 1'b1, 12'h001},
            '{8'h80, 4'h8, 1'b0, 12'h400}
        };
        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp_r, 0, $sformatf("vec%0d", i));

        do_op(8'hFF, 4'hF, 1'b1, 12'hE85, 7, "backpressure");

        for (int m = 0; m < 2; m++)
            for (int a = 0; a < (1 << WA); a++)
                for (int b = 0; b < (1 << WB); b++)
                    do_op(WA'(a), WB'(b), 1'(m),
                          m ? ref_mul(WA'(a), WB'(b), 1'b1) : N'(a * b), 0,
                          $sformatf("sweep_m%0d_a%0h_b%0h", m, a, b));

        for (int i = 0; i < 200; i++) begin
            logic [WA-1:0] ra = WA'($urandom);
            logic [WB-1:0] rb = WB'($urandom);
            logic          rm = 1'($urandom);
            do_op(ra, rb, rm, ref_mul(ra, rb, rm), int'($urandom_range(0, 3)),
                  $sformatf("rand%0d", i));
        end

        // Back-to-back: second operand waits with in_valid high and is taken at the handshake.
        bus.in_valid  = 1'b1;
        bus.a         = 8'hB7;
        bus.b         = 4'hD;
        bus.approx_en = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.a         = 8'h6C;
        bus.b         = 4'h9;
        bus.approx_en = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        chk("b2b.lat1", cnt, WB);
        res1 = bus.result;
        chk("b2b.result1", res1, ref_mul(8'hB7, 4'hD, 1'b1));
        chk("b2b.approx1", bus.out_approx, 1);
        chk("b2b.in_ready_done", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("b2b.valid_drop", bus.out_valid, 0);
        chk("b2b.in_ready_run", bus.in_ready, 0);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        chk("b2b.spacing", cnt + 1, WB + 1);
        chk("b2b.result2", bus.result, 12'h6C * 12'h9);
        chk("b2b.approx2", bus.out_approx, 0);
        step();
        bus.out_ready = 1'b0;
        chk("b2b.post_valid", bus.out_valid, 0);

        // Reset at row counter 2 aborts the operation with no result pulse afterwards.
        bus.in_valid  = 1'b1;
        bus.a         = 8'hFF;
        bus.b         = 4'hF;
        bus.approx_en = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort.valid_in_rst", bus.out_valid, 0);
        step();
        rst = 1'b0;
        #1;
        chk("abort.out_valid", bus.out_valid, 0);
        chk("abort.result", bus.result, 0);
        chk("abort.in_ready", bus.in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.out_valid) cnt++;
        end
        chk("abort.no_pulse", cnt, 0);
        do_op(8'h12, 4'h5, 1'b0, 12'h05A, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cd_mult_seq.md
Name: cd_mult_seq

Overview:
- Parametrised, sequential carry-disregard approximate multiplier: unsigned WA x WB.
- Accumulates one partial-product row per cycle, with valid/ready handshakes on input and output.
- In the low K columns, partial products are combined by XOR, with no carry generated or propagated; columns K and above use exact addition.
- Generalises the fixed 8x4 combinational carry-disregard cells. Adds runtime exact/approximate mode and backpressure, for use in area-constrained datapaths.

Parameters:
- WA, 8, multiplicand width (>=2).
- WB, 4, multiplier width = number of accumulation rows (>=1).
- K, 5, number of carry-disregard low columns (0..WA+WB); K=0 is exact.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WA  multiplicand, unsigned.
- b  in  WB  multiplier, unsigned.
- approx_en  in  1  1 = carry-disregard in low K columns; 0 = exact product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WA+WB  product.
- out_approx  out  1  approx_en value latched with these operands.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: state=IDLE, acc=0, row counter=0, latched a/b/mode=0, out_valid=0, result=0, out_approx=0. in_ready=1 once rst deasserts.
- States:
  - IDLE: in_ready=1. Accept on in_valid: latch a, b, approx_en; clear acc; cnt=0; go to RUN.
  - RUN: in_ready=0. Each cycle add row cnt into acc, cnt++. The edge that adds row WB-1 moves to DONE.
  - DONE: out_valid=1; result=acc and out_approx held stable.
    - out_valid & out_ready: go to IDLE.
    - If in_valid is also high in that cycle, accept the new operands instead and go directly to RUN.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready.
- Latency: out_valid asserts exactly WB cycles after the accept edge. Minimum initiation interval is WB+1 cycles.
- Row i value: r_i = (a & {WA{b[i]}}) << i, zero-extended to WA+WB bits.
- Accumulation step, Keff = approx_en_latched ? K : 0:
  - Low field: acc[Keff-1:0] <= acc[Keff-1:0] XOR r_i[Keff-1:0].
  - High field: acc[WA+WB-1:Keff] <= acc[WA+WB-1:Keff] + r_i[WA+WB-1:Keff], carry-in 0, modulo 2^(WA+WB-Keff).
  - The carry out of column Keff-1 is discarded.
  - When Keff = WA+WB the whole word is XOR.
  - The high field cannot overflow, since it is bounded by the exact product >> Keff.
- Exact mode (approx_en=0) must equal a*b bit-exactly for all inputs.
- a=0 or b=0 gives result 0 in both modes. A zero row still consumes its cycle; there is no early termination.
- Changes on a, b, approx_en outside the accept cycle have no effect.
- result and out_approx change only on the DONE->RUN/IDLE transition or on reset. They are held unchanged while out_ready is low, for any number of cycles.
- out_valid deasserts on the edge after the handshake, unless a new operation completes later.
- Reset asserted mid-RUN or in DONE aborts immediately (asynchronously). The in-flight result is discarded; no out_valid pulse follows.
- Parameter checks: K > WA+WB or WB < 1 is a generate-time error.

Test Plan:
- WA=8, WB=4, K=5; a=0xFF, b=0xF, approx_en=1 -> out_valid exactly 4 cycles after accept; result=0xE85 (low field 0x05, high field 0x74); out_approx=1.
- Same operands with approx_en=0 -> result=0xEF1 (3825); out_approx=0. Exhaustive sweep of all 4096 a/b pairs in exact mode -> result == a*b; in approx mode -> result matches the XOR/add reference model.
- a=0x03, b=0x3, approx_en=1 -> result=0x005 (exact 0x009), demonstrating dropped carry. a=0x05, b=0x3 -> result=0x00F (error-free).
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> result, out_approx and out_valid stable; in_ready=0 throughout; a/b toggled meanwhile have no effect.
- Back-to-back: in_valid held high with out_ready=1 -> second operand accepted in the DONE handshake cycle; outputs spaced WB+1 cycles apart; both results correct.
- Assert rst for 1 cycle at RUN cnt=2 -> out_valid=0, result=0, in_ready=1 immediately after rst falls. Next operation a=0x12, b=0x5, approx_en=0 -> result=0x05A.
